// File: rtl/pc_next_ctrl.sv
// pc_next_ctrl: next-PC select plus fetch-stall / halt control.
// Picks seq / branch / jump / jump-register targets, holds the PC while
// instruction memory is not ready and remembers the latest redirect seen
// during the stall. HALT is sticky until reset. stall_cnt saturates.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned JR traps to EXC_VECTOR).
module pc_next_ctrl #(
    parameter int                  PC_WIDTH   = 32,
    parameter logic [PC_WIDTH-1:0] EXC_VECTOR = PC_WIDTH'(32'h0000_0180),
    parameter int                  CNT_WIDTH  = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [PC_WIDTH-1:0]  PC_in,
    input  logic                 imem_ready,
    input  logic                 branch_take,
    input  logic [15:0]          branch_off,
    input  logic                 jump,
    input  logic [25:0]          jump_idx,
    input  logic                 jump_reg,
    input  logic [PC_WIDTH-1:0]  reg_target,
    input  logic                 halt_req,
    output logic [PC_WIDTH-1:0]  PC_next,
    output logic                 stalled,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic                 exc,
    output logic [PC_WIDTH-1:0]  epc
);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_STALL = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    logic [1:0]          state, state_n;
    logic                pend_valid, pend_trap;
    logic [PC_WIDTH-1:0] pend_target;

    logic [PC_WIDTH-1:0] seq_tgt, br_tgt, jmp_tgt, jr_tgt, sel_tgt;
    logic                redir, jr_trap, take_trap, capture;

    assign seq_tgt = PC_in + PC_WIDTH'(4);
    assign br_tgt  = seq_tgt + {{(PC_WIDTH-18){branch_off[15]}}, branch_off, 2'b00};
    assign jmp_tgt = {seq_tgt[PC_WIDTH-1:28], jump_idx, 2'b00};
    assign redir   = jump_reg | jump | branch_take;

`ifdef MISALIGN_TRAP_EN
    assign jr_trap = jump_reg & (|reg_target[1:0]);
    assign jr_tgt  = reg_target;
`else
    // Low bits are simply dropped when trapping is not built in.
    assign jr_trap = 1'b0;
    assign jr_tgt  = {reg_target[PC_WIDTH-1:2], 2'b00};
`endif

    // Redirect priority: jump_reg > jump > branch > sequential.
    always_comb begin
        sel_tgt = seq_tgt;
        if (jump_reg)         sel_tgt = jr_trap ? EXC_VECTOR : jr_tgt;
        else if (jump)        sel_tgt = jmp_tgt;
        else if (branch_take) sel_tgt = br_tgt;
    end

    // Next-state / next-PC decode; PC is held unless a ready cycle resolves it.
    always_comb begin
        state_n   = state;
        PC_next   = PC_in;
        take_trap = 1'b0;
        capture   = 1'b0;
        case (state)
            S_RUN: begin
                if (!imem_ready) begin
                    state_n = S_STALL;
                    capture = redir;
                end else if (halt_req) begin
                    state_n = S_HALT;
                end else begin
                    PC_next   = sel_tgt;
                    take_trap = jr_trap;
                end
            end
            S_STALL: begin
                if (!imem_ready) begin
                    capture = redir;
                end else if (halt_req) begin
                    state_n = S_HALT;
                end else begin
                    state_n = S_RUN;
                    // A redirect on the ready cycle is the latest one, so it wins.
                    if (redir) begin
                        PC_next   = sel_tgt;
                        take_trap = jr_trap;
                    end else if (pend_valid) begin
                        PC_next   = pend_target;
                        take_trap = pend_trap;
                    end else begin
                        PC_next   = seq_tgt;
                    end
                end
            end
            S_HALT:  ;
            default: state_n = S_RUN;
        endcase
        if (!RST) PC_next = '0;
    end

    // FSM state, pending redirect and saturating stall counter.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= S_RUN;
            pend_valid  <= 1'b0;
            pend_trap   <= 1'b0;
            pend_target <= '0;
            stall_cnt   <= '0;
        end else begin
            state <= state_n;
            if (capture) begin
                pend_valid  <= 1'b1;
                pend_target <= sel_tgt;
                pend_trap   <= jr_trap;
            end else if (state == S_STALL && imem_ready) begin
                pend_valid  <= 1'b0;
                pend_trap   <= 1'b0;
            end
            if (state != S_HALT && !imem_ready && stall_cnt != {CNT_WIDTH{1'b1}})
                stall_cnt <= stall_cnt + CNT_WIDTH'(1);
        end
    end

    assign stalled = (state == S_STALL);
    assign halted  = (state == S_HALT);

`ifdef MISALIGN_TRAP_EN
    // One-cycle trap pulse and the PC of the offending JR.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            exc <= 1'b0;
            epc <= '0;
        end else begin
            exc <= take_trap;
            if (take_trap) epc <= PC_in;
        end
    end
`else
    logic unused_trap;
    assign unused_trap = ^{reg_target[1:0], take_trap, pend_trap};
    assign exc = 1'b0;
    assign epc = '0;
`endif

endmodule

// File: tb/tb_pc_next_ctrl.sv
// Bench for pc_next_ctrl: directed vectors with literal expectations, plus a
// spec-level model compared against the DUT on every falling clock edge.
module tb_pc_next_ctrl;
    localparam int W  = 32;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [W-1:0]  PC_in = '0;
    logic          imem_ready = 1'b0, branch_take = 1'b0, jump = 1'b0, jump_reg = 1'b0, halt_req = 1'b0;
    logic [15:0]   branch_off = '0;
    logic [25:0]   jump_idx = '0;
    logic [W-1:0]  reg_target = '0;
    logic [W-1:0]  PC_next, epc;
    logic          stalled, halted, exc;
    logic [CW-1:0] stall_cnt;

    always #5 CLK = ~CLK;

    pc_next_ctrl #(.PC_WIDTH(W), .CNT_WIDTH(CW)) dut (
        .CLK(CLK), .RST(RST), .PC_in(PC_in), .imem_ready(imem_ready),
        .branch_take(branch_take), .branch_off(branch_off), .jump(jump),
        .jump_idx(jump_idx), .jump_reg(jump_reg), .reg_target(reg_target),
        .halt_req(halt_req), .PC_next(PC_next), .stalled(stalled),
        .halted(halted), .stall_cnt(stall_cnt), .exc(exc), .epc(epc)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- spec model ----------------
    // mode: 0 = running, 1 = stalled, 2 = halted
    int           m_mode = 0;
    bit           m_pv = 0, m_ptrap = 0, m_exc = 0;
    logic [W-1:0] m_pt = '0, m_epc = '0;
    int           m_cnt = 0;

    // Target of whatever redirect is on the inputs right now.
    function automatic void redirect(output bit any, output logic [W-1:0] t, output bit trap);
        logic [W-1:0] seq;
        int off;
        seq  = PC_in + 32'd4;
        off  = $signed(branch_off);
        any  = jump_reg | jump | branch_take;
        trap = 1'b0;
        if (jump_reg) begin
`ifdef MISALIGN_TRAP_EN
            if (reg_target[1:0] != 2'b00) begin t = 32'h0000_0180; trap = 1'b1; end
            else t = reg_target;
`else
            t = reg_target & ~32'h3;
`endif
        end else if (jump)        t = {seq[31:28], jump_idx, 2'b00};
        else if (branch_take)     t = seq + 32'(off * 4);
        else                      t = seq;
    endfunction

    function automatic logic [W-1:0] exp_pc(output bit trap);
        bit any, tr;
        logic [W-1:0] t;
        trap = 1'b0;
        if (!RST) return '0;
        if (m_mode == 2 || !imem_ready || halt_req) return PC_in;
        redirect(any, t, tr);
        if (any) begin trap = tr; return t; end
        if (m_mode == 1 && m_pv) begin trap = m_ptrap; return m_pt; end
        return PC_in + 32'd4;
    endfunction

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m_mode <= 0; m_pv <= 0; m_ptrap <= 0; m_pt <= '0;
            m_cnt <= 0; m_exc <= 0; m_epc <= '0;
        end else begin
            bit tr, any, rtr;
            logic [W-1:0] t, n_pt, n_epc;
            int n_mode, n_cnt;
            bit n_pv, n_ptrap, n_exc;
            void'(exp_pc(tr));
            n_mode = m_mode; n_cnt = m_cnt; n_pv = m_pv; n_ptrap = m_ptrap;
            n_pt = m_pt; n_exc = 1'b0; n_epc = m_epc;
            if (m_mode != 2) begin
                if (!imem_ready) begin
                    if (n_cnt < CNT_MAX) n_cnt++;
                    redirect(any, t, rtr);
                    if (any) begin n_pv = 1; n_pt = t; n_ptrap = rtr; end
                    n_mode = 1;
                end else begin
                    n_pv = 0; n_ptrap = 0;
                    if (halt_req) n_mode = 2;
                    else begin
                        n_mode = 0;
                        if (tr) begin n_exc = 1; n_epc = PC_in; end
                    end
                end
            end
            m_mode <= n_mode; m_cnt <= n_cnt; m_pv <= n_pv; m_ptrap <= n_ptrap;
            m_pt <= n_pt; m_exc <= n_exc; m_epc <= n_epc;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge CLK) begin
        bit tr;
        chk("mdl_pc_next", PC_next, exp_pc(tr));
        chk("mdl_stalled", W'(stalled), W'(m_mode == 1));
        chk("mdl_halted",  W'(halted),  W'(m_mode == 2));
        chk("mdl_stall_cnt", W'(stall_cnt), W'(m_cnt));
        chk("mdl_exc", W'(exc), W'(m_exc));
        chk("mdl_epc", epc, m_epc);
    end

    // ---------------- directed stimulus ----------------
    task automatic nxt();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input logic [W-1:0] pc);
        PC_in = pc; imem_ready = 1'b1;
        branch_take = 1'b0; jump = 1'b0; jump_reg = 1'b0; halt_req = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_pc_next", PC_next, 32'h0);
        chk("rst_stalled", W'(stalled), 32'h0);
        chk("rst_exc", W'(exc), 32'h0);

        // 1. release, sequential fetch
        RST = 1'b1;
        idle(32'h0);
        #1 chk("t1_pc_seq", PC_next, 32'h4);
        nxt();
        chk("t1_stalled", W'(stalled), 32'h0);
        chk("t1_cnt", W'(stall_cnt), 32'h0);

        // 2. backward branch, then jump over it
        idle(32'h100); branch_take = 1'b1; branch_off = 16'hFFFE;
        #1 chk("t2_branch", PC_next, 32'hFC);
        jump = 1'b1; jump_idx = 26'h40;
        #1 chk("t2_jump_wins", PC_next, 32'h100);
        nxt();

        // 3. stall with JR in first cycle only
        idle(32'h200); imem_ready = 1'b0; jump_reg = 1'b1; reg_target = 32'h400;
        #1 chk("t3_hold0", PC_next, 32'h200);
        nxt();
        jump_reg = 1'b0;
        chk("t3_stalled", W'(stalled), 32'h1);
        chk("t3_hold1", PC_next, 32'h200);
        nxt(); nxt();
        chk("t3_cnt3", W'(stall_cnt), 32'h3);
        imem_ready = 1'b1;
        #1 chk("t3_pend_applied", PC_next, 32'h400);
        nxt();
        chk("t3_unstalled", W'(stalled), 32'h0);

        // 6a. wrap-around
        idle(32'hFFFF_FFFC);
        #1 chk("t6_wrap", PC_next, 32'h0);
        nxt();

        // 5. misaligned JR
        idle(32'h40); jump_reg = 1'b1; reg_target = 32'h1002;
`ifdef MISALIGN_TRAP_EN
        #1 chk("t5_trap_pc", PC_next, 32'h180);
        nxt();
        chk("t5_exc", W'(exc), 32'h1);
        chk("t5_epc", epc, 32'h40);
        idle(32'h180);
        nxt();
        chk("t5_exc_pulse", W'(exc), 32'h0);
`else
        #1 chk("t5_jr_align", PC_next, 32'h1000);
        nxt();
        chk("t5_no_exc", W'(exc), 32'h0);
        idle(32'h1000);
        nxt();
`endif

        // 6b. reset while stalled with a pending jump
        idle(32'h300); imem_ready = 1'b0; jump = 1'b1; jump_idx = 26'h3FF;
        nxt();
        jump = 1'b0;
        chk("t6_stalled", W'(stalled), 32'h1);
        RST = 1'b0;
        #1 chk("t6_rst_stalled", W'(stalled), 32'h0);
        chk("t6_rst_pc", PC_next, 32'h0);
        RST = 1'b1; imem_ready = 1'b1;
        #1 chk("t6_pend_dropped", PC_next, 32'h304);
        nxt();

        // long stall: counter saturation and latest redirect wins
        idle(32'h500); imem_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            branch_take = (i == 1); branch_off = 16'h0004;
            jump = (i == 4); jump_idx = 26'h123;
            nxt();
        end
        chk("sat_cnt", W'(stall_cnt), W'(CNT_MAX));
        idle(32'h500);
        #1 chk("latest_wins", PC_next, 32'h48C);
        nxt();

        // 4. halt beats branch, then inputs are ignored
        idle(32'h80); branch_take = 1'b1; halt_req = 1'b1;
        #1 chk("t4_halt_pc", PC_next, 32'h80);
        nxt();
        chk("t4_halted", W'(halted), 32'h1);
        for (int i = 0; i < 6; i++) begin
            PC_in = $urandom; imem_ready = $urandom_range(0, 1);
            branch_take = $urandom_range(0, 1); jump = $urandom_range(0, 1);
            jump_reg = $urandom_range(0, 1); halt_req = $urandom_range(0, 1);
            reg_target = $urandom;
            #1 chk("t4_hold", PC_next, PC_in);
            nxt();
        end
        chk("t4_still_halted", W'(halted), 32'h1);
        RST = 1'b0;
        #1 chk("t4_rst_clears", W'(halted), 32'h0);
        RST = 1'b1;
        idle(32'h0);
        nxt();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
